// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   arb_state_t  : FSM encoding (IDLE / ISSUE / WAIT, 2 bits)
//   REQ_CORE     : requester id of the core (datapath) port
//   REQ_LOADER   : requester id of the loader port
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam logic REQ_CORE   = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

  // With only two requesters, the "other" requester is just the inverted id.
  function automatic logic other_id(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Two-way round-robin picker (purely combinational).
//   c_req       in  core request
//   l_req       in  loader request
//   last_grant  in  id of the requester granted most recently
//   grant_valid out at least one requester is asking
//   grant_id    out id of the winning requester (meaningful when grant_valid)
module rr_picker
  import mem_arbiter_pkg::*;
(
  input  logic c_req,
  input  logic l_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = c_req | l_req;
    grant_id    = REQ_CORE;
    if (c_req && l_req) begin
      // Tie: whoever did not win last time goes first.
      grant_id = other_id(last_grant);
    end else if (l_req) begin
      grant_id = REQ_LOADER;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between the core and the loader.
// Each access takes three cycles: IDLE (arbitrate + latch), ISSUE (memory
// strobe), WAIT (read data returns, winner is acked).
//
//   clock, rst                        clock and synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata         core request port
//   c_ack/c_rdata/c_stall             core completion, read data, stall
//   l_req/l_we/l_addr/l_wdata         loader request port
//   l_ack/l_rdata                     loader completion and read data
//   m_addr/m_writedata/m_write/m_read memory command (registered)
//   m_rdata                           memory read data, one cycle after m_read
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | arbitrate; on a request latch winner, addr, we, wdata
// ISSUE | memory strobe high for one cycle using the latched command
// WAIT  | memory data valid; winner ack high, read data captured
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              rst,
  // core port
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  // loader port
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_ack,
  output logic [DATA_W-1:0] l_rdata,
  // memory port
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_writedata,
  output logic              m_write,
  output logic              m_read,
  input  logic [DATA_W-1:0] m_rdata
);

  arb_state_t        state;
  logic              win_id;
  logic              lat_we;
  logic              last_grant;
  logic [DATA_W-1:0] c_rdata_q;
  logic [DATA_W-1:0] l_rdata_q;

  logic              grant_valid;
  logic              grant_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] wait_rdata;

  rr_picker u_rr_picker (
    .c_req       (c_req),
    .l_req       (l_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    sel_we    = c_we;
    sel_addr  = c_addr;
    sel_wdata = c_wdata;
    if (grant_id == REQ_LOADER) begin
      sel_we    = l_we;
      sel_addr  = l_addr;
      sel_wdata = l_wdata;
    end
  end

  // Memory data only arrives in WAIT, so the ack cycle shows it directly;
  // the register takes over from the following cycle on.
  assign wait_rdata = lat_we ? '0 : m_rdata;
  assign c_rdata    = c_ack ? wait_rdata : c_rdata_q;
  assign l_rdata    = l_ack ? wait_rdata : l_rdata_q;
  assign c_stall    = c_req & ~c_ack;

  // m_addr / m_writedata double as the latched address and write data;
  // they are only loaded on IDLE->ISSUE, so they hold between accesses.
  always_ff @(posedge clock) begin
    if (rst) begin
      state       <= IDLE;
      win_id      <= REQ_CORE;
      lat_we      <= 1'b0;
      last_grant  <= REQ_LOADER;
      m_addr      <= '0;
      m_writedata <= '0;
      m_write     <= 1'b0;
      m_read      <= 1'b0;
      c_ack       <= 1'b0;
      l_ack       <= 1'b0;
      c_rdata_q   <= '0;
      l_rdata_q   <= '0;
    end else begin
      m_write <= 1'b0;
      m_read  <= 1'b0;
      c_ack   <= 1'b0;
      l_ack   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            win_id      <= grant_id;
            last_grant  <= grant_id;
            lat_we      <= sel_we;
            m_addr      <= sel_addr;
            m_writedata <= sel_wdata;
            m_write     <= sel_we;
            m_read      <= ~sel_we;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          c_ack <= (win_id == REQ_CORE);
          l_ack <= (win_id == REQ_LOADER);
          state <= WAIT;
        end
        WAIT: begin
          if (win_id == REQ_CORE) begin
            c_rdata_q <= wait_rdata;
          end else begin
            l_rdata_q <= wait_rdata;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  logic              clock = 1'b0;
  logic              rst;
  logic              c_req, c_we, l_req, l_we;
  logic [ADDR_W-1:0] c_addr, l_addr;
  logic [DATA_W-1:0] c_wdata, l_wdata;
  logic              c_ack, l_ack, c_stall;
  logic [DATA_W-1:0] c_rdata, l_rdata;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_writedata;
  logic              m_write, m_read;
  logic [DATA_W-1:0] m_rdata;

  logic              mem_init;
  logic [DATA_W-1:0] mem [0:255];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock       (clock),
    .rst         (rst),
    .c_req       (c_req),
    .c_we        (c_we),
    .c_addr      (c_addr),
    .c_wdata     (c_wdata),
    .c_ack       (c_ack),
    .c_rdata     (c_rdata),
    .c_stall     (c_stall),
    .l_req       (l_req),
    .l_we        (l_we),
    .l_addr      (l_addr),
    .l_wdata     (l_wdata),
    .l_ack       (l_ack),
    .l_rdata     (l_rdata),
    .m_addr      (m_addr),
    .m_writedata (m_writedata),
    .m_write     (m_write),
    .m_read      (m_read),
    .m_rdata     (m_rdata)
  );

  // Synchronous memory: read data registered, valid the cycle after m_read.
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[8'h10] <= 16'hBEEF;
      m_rdata    <= '0;
    end else begin
      if (m_write) mem[m_addr[7:0]] <= m_writedata;
      if (m_read)  m_rdata <= mem[m_addr[7:0]];
    end
  end

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic sample;
    @(negedge clock);
  endtask

  task automatic clear_inputs;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
  endtask

  task automatic test_reset;
    rst = 1;
    next_cycle;
    next_cycle;
    sample;
    n_tests++;
    if ({m_write, m_read, c_ack, l_ack, c_stall} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, expected 00000", {m_write, m_read, c_ack, l_ack, c_stall});
    end
    n_tests++;
    if ({m_addr, m_writedata, c_rdata, l_rdata} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h, expected 0", {m_addr, m_writedata, c_rdata, l_rdata});
    end
    next_cycle;
    rst = 0;
  endtask

  task automatic test_core_read;
    next_cycle;
    c_req = 1; c_we = 0; c_addr = 16'h0010;
    sample;
    n_tests++;
    if ({c_stall, m_read, c_ack} !== 3'b100) begin
      n_fail++;
      $display("FAIL core_read_c0: got stall/rd/ack %b, expected 100", {c_stall, m_read, c_ack});
    end
    next_cycle;
    sample;
    n_tests++;
    if ({c_stall, m_read, m_write, c_ack} !== 4'b1100 || m_addr !== 16'h0010) begin
      n_fail++;
      $display("FAIL core_read_c1: got stall/rd/wr/ack %b addr %h, expected 1100 addr 0010",
               {c_stall, m_read, m_write, c_ack}, m_addr);
    end
    next_cycle;
    sample;
    n_tests++;
    if ({c_stall, m_read, c_ack, l_ack} !== 4'b0010 || c_rdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL core_read_c2: got stall/rd/cack/lack %b rdata %h, expected 0010 rdata beef",
               {c_stall, m_read, c_ack, l_ack}, c_rdata);
    end
    c_req = 0;
    next_cycle;
    sample;
    n_tests++;
    if (c_ack !== 1'b0 || c_rdata !== 16'hBEEF || m_addr !== 16'h0010) begin
      n_fail++;
      $display("FAIL core_read_hold: got ack %b rdata %h addr %h, expected 0 beef 0010",
               c_ack, c_rdata, m_addr);
    end
  endtask

  task automatic test_loader_write;
    next_cycle;
    l_req = 1; l_we = 1; l_addr = 16'h0004; l_wdata = 16'h1234;
    next_cycle;
    sample;
    n_tests++;
    if ({m_write, m_read, l_ack} !== 3'b100 || m_addr !== 16'h0004 || m_writedata !== 16'h1234) begin
      n_fail++;
      $display("FAIL loader_write_c1: got wr/rd/ack %b addr %h wd %h, expected 100 0004 1234",
               {m_write, m_read, l_ack}, m_addr, m_writedata);
    end
    next_cycle;
    sample;
    n_tests++;
    if ({l_ack, c_ack, m_write} !== 3'b100 || l_rdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL loader_write_c2: got lack/cack/wr %b rdata %h, expected 100 0000",
               {l_ack, c_ack, m_write}, l_rdata);
    end
    l_req = 0; l_we = 0;
    next_cycle;
    sample;
    n_tests++;
    if (m_write !== 1'b0 || m_addr !== 16'h0004 || m_writedata !== 16'h1234) begin
      n_fail++;
      $display("FAIL loader_write_idle: got wr %b addr %h wd %h, expected 0 0004 1234",
               m_write, m_addr, m_writedata);
    end
    // read back through the core port
    c_req = 1; c_we = 0; c_addr = 16'h0004;
    next_cycle;
    next_cycle;
    sample;
    n_tests++;
    if (c_ack !== 1'b1 || c_rdata !== 16'h1234) begin
      n_fail++;
      $display("FAIL loader_readback: got ack %b rdata %h, expected 1 1234", c_ack, c_rdata);
    end
    c_req = 0;
    next_cycle;
  endtask

  task automatic test_back_to_back;
    logic              exp_c, exp_l;
    logic [ADDR_W-1:0] exp_addr;
    next_cycle;
    rst = 1;
    next_cycle;
    rst = 0;
    c_req = 1; c_we = 0; c_addr = 16'h0010;
    l_req = 1; l_we = 0; l_addr = 16'h0004;
    for (int cyc = 0; cyc < 12; cyc++) begin
      sample;
      exp_c = (cyc == 2) || (cyc == 8);
      exp_l = (cyc == 5) || (cyc == 11);
      n_tests++;
      if (c_ack !== exp_c || l_ack !== exp_l || c_stall !== ~exp_c) begin
        n_fail++;
        $display("FAIL b2b_ack cyc %0d: got cack/lack/stall %b%b%b, expected %b%b%b",
                 cyc, c_ack, l_ack, c_stall, exp_c, exp_l, ~exp_c);
      end
      n_tests++;
      if ((m_read && m_write) || (c_ack && l_ack)) begin
        n_fail++;
        $display("FAIL b2b_exclusive cyc %0d: got rd/wr %b%b cack/lack %b%b, expected no overlap",
                 cyc, m_read, m_write, c_ack, l_ack);
      end
      if (cyc % 3 == 1) begin
        exp_addr = (cyc % 6 == 1) ? 16'h0010 : 16'h0004;
        n_tests++;
        if (m_read !== 1'b1 || m_addr !== exp_addr) begin
          n_fail++;
          $display("FAIL b2b_issue cyc %0d: got rd %b addr %h, expected 1 %h", cyc, m_read, m_addr, exp_addr);
        end
      end
      if (cyc == 2) begin
        n_tests++;
        if (c_rdata !== 16'hBEEF) begin
          n_fail++;
          $display("FAIL b2b_c_rdata: got %h, expected beef", c_rdata);
        end
      end
      if (cyc == 5) begin
        n_tests++;
        if (l_rdata !== 16'h1234) begin
          n_fail++;
          $display("FAIL b2b_l_rdata: got %h, expected 1234", l_rdata);
        end
      end
      next_cycle;
    end
    clear_inputs;
    sample;
    n_tests++;
    if ({m_read, m_write, c_ack, l_ack} !== 4'b0) begin
      n_fail++;
      $display("FAIL b2b_end: got %b, expected 0000", {m_read, m_write, c_ack, l_ack});
    end
    next_cycle;
  endtask

  task automatic test_reset_mid_issue;
    next_cycle;
    c_req = 1; c_we = 1; c_addr = 16'h0020; c_wdata = 16'hAAAA;
    next_cycle;
    rst = 1;
    sample;
    n_tests++;
    if (m_write !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_issue_pre: got wr %b, expected 1", m_write);
    end
    next_cycle;
    rst = 0;
    c_req = 0;
    sample;
    n_tests++;
    if ({m_write, m_read, c_ack, l_ack} !== 4'b0 || m_addr !== 16'h0 || m_writedata !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_mid_issue_post: got ctrl %b addr %h wd %h, expected 0000 0000 0000",
               {m_write, m_read, c_ack, l_ack}, m_addr, m_writedata);
    end
    next_cycle;
    sample;
    n_tests++;
    if (c_ack !== 1'b0 || m_read !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_ack: got ack %b rd %b, expected 0 0", c_ack, m_read);
    end
    // tie right after reset must go to the core
    c_req = 1; c_we = 0; c_addr = 16'h0010;
    l_req = 1; l_we = 0; l_addr = 16'h0004;
    next_cycle;
    sample;
    n_tests++;
    if (m_read !== 1'b1 || m_addr !== 16'h0010) begin
      n_fail++;
      $display("FAIL rst_tie_issue: got rd %b addr %h, expected 1 0010", m_read, m_addr);
    end
    next_cycle;
    sample;
    n_tests++;
    if (c_ack !== 1'b1 || l_ack !== 1'b0 || c_rdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL rst_tie_ack: got cack %b lack %b rdata %h, expected 1 0 beef", c_ack, l_ack, c_rdata);
    end
    clear_inputs;
    next_cycle;
  endtask

  task automatic test_drop_req;
    int ack_count;
    int read_count;
    next_cycle;
    c_req = 1; c_we = 0; c_addr = 16'h0004;
    next_cycle;
    // request withdrawn and address changed while ISSUE is in progress
    c_req = 0; c_addr = 16'h0010;
    sample;
    n_tests++;
    if (m_read !== 1'b1 || m_addr !== 16'h0004) begin
      n_fail++;
      $display("FAIL drop_issue: got rd %b addr %h, expected 1 0004", m_read, m_addr);
    end
    ack_count = 0;
    read_count = 0;
    for (int cyc = 2; cyc < 8; cyc++) begin
      next_cycle;
      sample;
      if (c_ack) ack_count++;
      if (m_read || m_write) read_count++;
      if (cyc == 2) begin
        n_tests++;
        if (c_ack !== 1'b1 || c_rdata !== 16'h1234) begin
          n_fail++;
          $display("FAIL drop_ack: got ack %b rdata %h, expected 1 1234", c_ack, c_rdata);
        end
      end
    end
    n_tests++;
    if (ack_count != 1 || read_count != 0) begin
      n_fail++;
      $display("FAIL drop_once: got acks %0d strobes %0d, expected 1 0", ack_count, read_count);
    end
    n_tests++;
    if (c_rdata !== 16'h1234 || m_addr !== 16'h0004) begin
      n_fail++;
      $display("FAIL drop_hold: got rdata %h addr %h, expected 1234 0004", c_rdata, m_addr);
    end
  endtask

  initial begin
    clear_inputs;
    rst = 1;
    mem_init = 1;
    next_cycle;
    mem_init = 0;
    test_reset;
    test_core_read;
    test_loader_write;
    test_back_to_back;
    test_reset_mid_issue;
    test_drop_req;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, memory data width.
REQ-002 Parameter ADDR_W, default 16, memory address width.
REQ-003 Single clock, reset synchronous and active-high; all state updates on posedge clock; rst sampled only at posedge.
REQ-004 clock  in  1  system clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 c_req  in  1  core (datapath) access request, held until c_ack.
REQ-007 c_we  in  1  core write (1) / read (0).
REQ-008 c_addr  in  ADDR_W  core address.
REQ-009 c_wdata  in  DATA_W  core write data.
REQ-010 c_ack  out  1  one-cycle completion pulse to core.
REQ-011 c_rdata  out  DATA_W  core read data, valid while c_ack=1.
REQ-012 c_stall  out  1  core must hold PC/IR: c_req and not c_ack.
REQ-013 l_req, l_we, l_addr, l_wdata, l_ack, l_rdata: loader port, same widths and directions as core port.
REQ-014 m_addr  out  ADDR_W  memory address.
REQ-015 m_writedata  out  DATA_W  memory write data.
REQ-016 m_write  out  1  memory write strobe.
REQ-017 m_read  out  1  memory read strobe.
REQ-018 m_rdata  in  DATA_W  memory read data, valid one cycle after m_read.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT; reset state IDLE.
REQ-020 IDLE: if any req, latch winner id, addr, we, wdata; go ISSUE; else stay.
REQ-021 Arbitration: single requester wins; both requesting -> requester not in last_grant wins (round robin).
REQ-022 last_grant updated on every IDLE->ISSUE; reset value LOADER, so core wins first tie.
REQ-023 ISSUE (exactly one cycle): m_addr/m_writedata from latched values, m_write=we, m_read=~we; go WAIT.
REQ-024 WAIT (exactly one cycle): winner ack=1, winner rdata=m_rdata captured into register (write: rdata = 0); go IDLE.
REQ-025 Outside ISSUE, m_write=m_read=0 and m_addr/m_writedata hold last value.
REQ-026 Latency: req sampled at edge N -> ack high in cycle N+2; max throughput one access per 3 cycles.
REQ-027 Requester keeping req high after ack -> new transaction; re-arbitrated in next IDLE.
REQ-028 req dropped after latch (ISSUE/WAIT) -> transaction still completes, ack still pulses.
REQ-029 Request inputs changing during ISSUE/WAIT ignored; only latched copies drive memory.
REQ-030 Never m_write and m_read high together; never both acks high together.
REQ-031 c_rdata/l_rdata hold last captured value between acks.

Reset
REQ-032 rst at any edge, including mid-ISSUE/WAIT: next cycle state IDLE, m_write=m_read=0, c_ack=l_ack=0, last_grant=LOADER, m_addr/m_writedata/c_rdata/l_rdata=0; aborted transaction not acked.
REQ-033 rst has priority over all FSM transitions.

Structure
REQ-034 Shared package holds state encoding (IDLE/ISSUE/WAIT, 2 bits) and requester id constants (CORE=0, LOADER=1).
REQ-035 One sub-module, rr_picker: combinational two-way round-robin select from (c_req, l_req, last_grant); FSM and latches stay in mem_arbiter.

Verification
REQ-036 Core read only: c_req=1, c_we=0, c_addr=0x0010, memory holds 0xBEEF -> m_read in cycle 1, c_ack and c_rdata=0xBEEF in cycle 2, c_stall=1 for cycles 0-1.
REQ-037 Loader write: l_we=1, l_addr=0x0004, l_wdata=0x1234 -> m_write=1, m_addr=0x0004 one cycle; then core read of 0x0004 returns 0x1234.
REQ-038 Simultaneous c_req and l_req after reset, both held 12 cycles -> grants alternate core, loader, core, loader; acks at cycles 2, 5, 8, 11.
REQ-039 rst asserted during ISSUE of a core write -> no c_ack, m_write low next cycle, FSM IDLE, next tie goes to core.
REQ-040 Core drops c_req in ISSUE -> c_ack still pulses once in WAIT; no second transaction issued.
